// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared constants and helpers for the hazard scoreboard slice.
//   REG_W        register index width
//   NREG         architectural register count
//   X0_IDX       hard-wired zero register index
//   MAX_OUT_DEF  default limit of outstanding long-latency writes
//   CNT_W        width of the outstanding-write counter
//   reg_mask()   one-hot register mask, empty for x0
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int REG_W       = 5;
    localparam int NREG        = 32;
    localparam int MAX_OUT_DEF = 4;
    localparam int CNT_W       = 4;

    localparam logic [REG_W-1:0] X0_IDX = '0;

    // One-hot mask for a register; x0 yields an empty mask so that any
    // set or clear aimed at x0 drops out naturally.
    function automatic logic [NREG-1:0] reg_mask(input logic [REG_W-1:0] r);
        logic [NREG-1:0] m;
        m = '0;
        if (r != X0_IDX) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundle of the decode/write-back request signals and the scoreboard
// responses.
//   master : decode + write-back side (drives id_*, flush, wb_*)
//   slave  : scoreboard side (drives stall_id, issue_fire, pending,
//            out_cnt, sb_err)
// Handshake: an instruction is accepted in the cycle where
// id_valid=1, stall_id=0 and flush=0 (issue_fire=1); the decode side
// keeps the same instruction on id_* while stall_id is high.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if;
    import hazard_scoreboard_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic             id_rs1_used;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_we;
    logic             id_long;
    logic             flush;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             stall_id;
    logic             issue_fire;
    logic [NREG-1:0]  pending;
    logic [CNT_W-1:0] out_cnt;
    logic             sb_err;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_we, id_long, flush, wb_valid, wb_rd,
        input  stall_id, issue_fire, pending, out_cnt, sb_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_we, id_long, flush, wb_valid, wb_rd,
        output stall_id, issue_fire, pending, out_cnt, sb_err
    );

endinterface

// File: rtl/hazard_scoreboard_sb_out_ctr.sv
// ---------------------------------------------------------------------------
// sb_out_ctr
// Saturating up/down counter of outstanding long-latency writes.
//   clk, rstn : clock, asynchronous active-low reset
//   inc       : one new outstanding write
//   dec       : one outstanding write retired
//   cnt       : current count (0..MAX_OUT)
//   full      : cnt == MAX_OUT
//   empty     : cnt == 0
// inc and dec together leave the count unchanged. An inc while full or a
// dec while empty is ignored so the count never leaves 0..MAX_OUT.
// ---------------------------------------------------------------------------
module sb_out_ctr
    import hazard_scoreboard_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] cnt_q;

    assign full  = (cnt_q == CNT_MAX);
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   if (!full)  cnt_q <= cnt_q + 1'b1;
                2'b01:   if (!empty) cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Register scoreboard for long-latency producers (loads, divides).
// Tracks one pending bit per register and stalls decode on RAW/WAW
// hazards against outstanding long writes, or when the outstanding
// limit MAX_OUT is reached.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   id_valid                decode holds an instruction
//   id_rs1/_used            source 1 index / is read
//   id_rs2/_used            source 2 index / is read
//   id_rd, id_we, id_long   destination, writes rd, long-latency producer
//   flush                   kill the decode instruction this cycle
//   wb_valid, wb_rd         long-latency write-back
//   stall_id                hold IF/ID, bubble into EX (combinational)
//   issue_fire              instruction accepted this cycle
//   pending[31:0]           outstanding-write bits (bit 0 always 0)
//   out_cnt[3:0]            outstanding long writes
//   sb_err                  sticky: write-back to a non-pending register
//
// Build option: SCOREBOARD_WB_BYPASS_EN -- a register being cleared by
// wb_valid in the current cycle is not treated as pending by the hazard
// compare, so a dependent instruction issues in the write-back cycle.
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_long,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic             stall_id,
    output logic             issue_fire,
    output logic [NREG-1:0]  pending,
    output logic [CNT_W-1:0] out_cnt,
    output logic             sb_err
);

    logic [NREG-1:0]  pending_q;
    logic [NREG-1:0]  pending_nxt;
    logic [NREG-1:0]  pending_eff;
    logic [NREG-1:0]  clr_mask;
    logic [NREG-1:0]  set_mask;
    logic             wb_hit;
    logic             wb_spur;
    logic             set_fire;
    logic             haz_rs1;
    logic             haz_rs2;
    logic             haz_waw;
    logic             haz_full;
    logic             cnt_full;
    logic             cnt_empty;
    logic             cnt_dec;
    logic             err_q;
    logic [CNT_W-1:0] cnt;

    // Write-back classification; x0 write-backs are ignored entirely.
    assign wb_hit  = wb_valid & (wb_rd != X0_IDX) &  pending_q[wb_rd];
    assign wb_spur = wb_valid & (wb_rd != X0_IDX) & ~pending_q[wb_rd];

    assign clr_mask = wb_hit ? reg_mask(wb_rd) : '0;

    // View of pending used by the hazard compare.
`ifdef SCOREBOARD_WB_BYPASS_EN
    assign pending_eff = pending_q & ~clr_mask;
`else
    assign pending_eff = pending_q;
`endif

    assign haz_rs1  = id_rs1_used & (id_rs1 != X0_IDX) & pending_eff[id_rs1];
    assign haz_rs2  = id_rs2_used & (id_rs2 != X0_IDX) & pending_eff[id_rs2];
    assign haz_waw  = id_we       & (id_rd  != X0_IDX) & pending_eff[id_rd];
    // Limit check uses the registered count only; a slot freed this
    // cycle becomes usable next cycle.
    assign haz_full = id_long & id_we & (id_rd != X0_IDX) & cnt_full;

    assign stall_id   = id_valid & (haz_rs1 | haz_rs2 | haz_waw | haz_full);
    assign issue_fire = id_valid & ~stall_id & ~flush;

    // Only accepted long producers create outstanding writes.
    assign set_fire = issue_fire & id_we & id_long & (id_rd != X0_IDX);
    assign set_mask = set_fire ? reg_mask(id_rd) : '0;

    // Clear before set: a same-register set and clear leaves the bit set.
    always_comb begin
        pending_nxt    = (pending_q & ~clr_mask) | set_mask;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (wb_spur) begin
            err_q <= 1'b1;
        end
    end

    // A hit always implies a non-zero count; the empty guard keeps the
    // counter from underflowing should the two ever disagree.
    assign cnt_dec = wb_hit & ~cnt_empty;

    sb_out_ctr #(
        .MAX_OUT (MAX_OUT)
    ) u_out_ctr (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (set_fire),
        .dec   (cnt_dec),
        .cnt   (cnt),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    assign pending = pending_q;
    assign out_cnt = cnt;
    assign sb_err  = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int MAX_OUT = 4;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    hazard_scoreboard_if ifc ();

    hazard_scoreboard #(.MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .id_valid    (ifc.id_valid),
        .id_rs1      (ifc.id_rs1),
        .id_rs1_used (ifc.id_rs1_used),
        .id_rs2      (ifc.id_rs2),
        .id_rs2_used (ifc.id_rs2_used),
        .id_rd       (ifc.id_rd),
        .id_we       (ifc.id_we),
        .id_long     (ifc.id_long),
        .flush       (ifc.flush),
        .wb_valid    (ifc.wb_valid),
        .wb_rd       (ifc.wb_rd),
        .stall_id    (ifc.stall_id),
        .issue_fire  (ifc.issue_fire),
        .pending     (ifc.pending),
        .out_cnt     (ifc.out_cnt),
        .sb_err      (ifc.sb_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int rs1, input logic r1u, input int rs2,
                         input logic r2u, input int rd, input logic we, input logic lng,
                         input logic fl, input logic wbv, input int wbrd);
        ifc.id_valid    = v;
        ifc.id_rs1      = REG_W'(rs1);
        ifc.id_rs1_used = r1u;
        ifc.id_rs2      = REG_W'(rs2);
        ifc.id_rs2_used = r2u;
        ifc.id_rd       = REG_W'(rd);
        ifc.id_we       = we;
        ifc.id_long     = lng;
        ifc.flush       = fl;
        ifc.wb_valid    = wbv;
        ifc.wb_rd       = REG_W'(wbrd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Inputs are applied 1 time unit after a rising edge; combinational
    // outputs are checked 1 unit later, then the bench advances one cycle.
    task automatic step(input string name, input logic es, input logic ef);
        #1;
        chk({name, ".stall"}, ifc.stall_id, es);
        chk({name, ".fire"}, ifc.issue_fire, ef);
        @(posedge clk);
        #1;
    endtask

    task automatic long_op(input int rd);
        drive(1, 0, 0, 0, 0, rd, 1, 1, 0, 0, 0);
        step("long_op", 0, 1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic v; int rs1; logic r1u; int rs2; logic r2u; int rd;
        logic we; logic lng; logic fl; logic wbv; int wbrd;
        logic e_stall; logic e_fire; int e_cnt; logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(logic v, int rs1, logic r1u, int rs2, logic r2u, int rd,
                                logic we, logic lng, logic fl, logic wbv, int wbrd,
                                logic es, logic ef, int ec, logic [31:0] ep);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.r1u = r1u; t.rs2 = rs2; t.r2u = r2u; t.rd = rd;
        t.we = we; t.lng = lng; t.fl = fl; t.wbv = wbv; t.wbrd = wbrd;
        t.e_stall = es; t.e_fire = ef; t.e_cnt = ec; t.e_pend = ep;
        return t;
    endfunction

    // ---------------- reference model ----------------
    bit [31:0] m_pend;
    bit        m_err;

    function automatic bit m_is_pend(int r, bit wbv, int wbrd);
        if (r == 0) return 0;
        if (BYP && wbv && wbrd == r && m_pend[r]) return 0;
        return m_pend[r];
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    initial begin
        rstn = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pending", ifc.pending, 32'h0);
        chk("rst.out_cnt", 32'(ifc.out_cnt), 0);
        chk("rst.sb_err", ifc.sb_err, 1'b0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ---- table-driven vectors ----
        //            v rs1 u rs2 u rd we lg fl wbv wbrd  stall fire cnt pend
        tbl[0]  = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,   0, 1, 1, 32'h20);
        tbl[1]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 32'h20);
        tbl[2]  = mk(1, 6, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 32'h20);
        tbl[3]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,   1, 0, 1, 32'h20);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   0, 0, 0, 32'h0);
        tbl[5]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 0, 32'h0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 1, 0, 32'h0);
        tbl[8]  = mk(1, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 8, 1, 1, 1, 0, 0,   0, 0, 0, 32'h0);
        tbl[10] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 32'h0);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].r1u, tbl[i].rs2, tbl[i].r2u, tbl[i].rd,
                  tbl[i].we, tbl[i].lng, tbl[i].fl, tbl[i].wbv, tbl[i].wbrd);
            step($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_fire);
            chk($sformatf("vec%0d.cnt", i), 32'(ifc.out_cnt), tbl[i].e_cnt);
            chk($sformatf("vec%0d.pend", i), ifc.pending, tbl[i].e_pend);
            chk($sformatf("vec%0d.err", i), ifc.sb_err, 1'b0);
        end

        // ---- load-use ----
        do_reset();
        long_op(5);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu.c1", 1, 0);
        step("lu.c2", 1, 0);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 5);
        step("lu.wb", !BYP, BYP);
        chk("lu.pend_after_wb", ifc.pending, 32'h0);
        if (!BYP) begin
            drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            step("lu.late", 0, 1);
        end
        chk("lu.cnt", 32'(ifc.out_cnt), 0);

        // ---- full ----
        do_reset();
        for (int r = 1; r <= 4; r++) long_op(r);
        chk("full.cnt4", 32'(ifc.out_cnt), 4);
        chk("full.pend", ifc.pending, 32'h1E);
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
        step("full.stall", 1, 0);
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 1, 2);
        step("full.wb", 1, 0);
        chk("full.cnt3", 32'(ifc.out_cnt), 3);
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
        step("full.go", 0, 1);
        chk("full.cnt_back", 32'(ifc.out_cnt), 4);
        chk("full.pend2", ifc.pending, 32'h5A);

        // ---- same-cycle set/clear ----
        do_reset();
        long_op(7);
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 7);
        step("same.issue", !BYP, BYP);
        chk("same.pend7", ifc.pending[7], BYP);
        chk("same.cnt", 32'(ifc.out_cnt), BYP ? 1 : 0);

        // ---- same-cycle set/clear on different registers ----
        do_reset();
        long_op(3);
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 1, 3);
        step("diff.issue", 0, 1);
        chk("diff.cnt", 32'(ifc.out_cnt), 1);
        chk("diff.pend", ifc.pending, 32'h10);

        // ---- x0 ----
        do_reset();
        long_op(0);
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step("x0.read", 0, 1);
        chk("x0.pend", ifc.pending, 32'h0);
        chk("x0.cnt", 32'(ifc.out_cnt), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("x0.wb", 0, 0);
        chk("x0.err", ifc.sb_err, 1'b0);

        // ---- spurious write-back, reset with outstanding writes ----
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        step("spur.wb", 0, 0);
        chk("spur.err", ifc.sb_err, 1'b1);
        chk("spur.pend", ifc.pending, 32'h0);
        idle();
        step("spur.idle", 0, 0);
        chk("spur.sticky", ifc.sb_err, 1'b1);
        long_op(1); long_op(2); long_op(3);
        chk("rst3.cnt_before", 32'(ifc.out_cnt), 3);
        rstn = 1'b0;
        idle();
        #1;
        chk("rst3.pend_async", ifc.pending, 32'h0);
        chk("rst3.cnt_async", 32'(ifc.out_cnt), 0);
        chk("rst3.err_async", ifc.sb_err, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        step("rst3.late_wb", 0, 0);
        chk("rst3.err", ifc.sb_err, 1'b1);

        // ---- flush ----
        do_reset();
        drive(1, 0, 0, 0, 0, 8, 1, 1, 1, 0, 0);
        step("flush", 0, 0);
        chk("flush.pend8", ifc.pending[8], 1'b0);
        chk("flush.cnt", 32'(ifc.out_cnt), 0);

        // ---- randomized against the reference model ----
        do_reset();
        m_pend = '0;
        m_err  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic v, r1u, r2u, we, lng, fl, wbv;
            int rs1, rs2, rd, wbrd;
            bit es, ef;
            v    = ($urandom_range(0, 3) != 0);
            rs1  = $urandom_range(0, 7);  r1u = $urandom_range(0, 1);
            rs2  = $urandom_range(0, 7);  r2u = $urandom_range(0, 1);
            rd   = $urandom_range(0, 7);  we  = ($urandom_range(0, 3) != 0);
            lng  = $urandom_range(0, 1);  fl  = ($urandom_range(0, 7) == 0);
            wbv  = ($urandom_range(0, 2) == 0);
            wbrd = $urandom_range(0, 7);
            // Bias write-backs toward registers that really are pending.
            if (wbv && m_pend != 0 && $urandom_range(0, 7) != 0) begin
                do wbrd = $urandom_range(1, 7); while (!m_pend[wbrd]);
            end
            es = v && ((r1u && m_is_pend(rs1, wbv, wbrd)) ||
                       (r2u && m_is_pend(rs2, wbv, wbrd)) ||
                       (we && m_is_pend(rd, wbv, wbrd)) ||
                       (lng && we && rd != 0 && $countones(m_pend) == MAX_OUT));
            ef = v && !es && !fl;
            if (wbv && wbrd != 0) begin
                if (m_pend[wbrd]) m_pend[wbrd] = 1'b0;
                else m_err = 1'b1;
            end
            if (ef && we && lng && rd != 0) m_pend[rd] = 1'b1;
            exp_q.push_back(m_pend);
            exp_q.push_back(32'($countones(m_pend)));
            exp_q.push_back(32'(m_err));
            drive(v, rs1, r1u, rs2, r2u, rd, we, lng, fl, wbv, wbrd);
            step($sformatf("rnd%0d", n), es, ef);
            chk($sformatf("rnd%0d.pend", n), ifc.pending, exp_q.pop_front());
            chk($sformatf("rnd%0d.cnt", n), 32'(ifc.out_cnt), exp_q.pop_front());
            chk($sformatf("rnd%0d.err", n), ifc.sb_err, exp_q.pop_front());
        end

        // ---- final report ----
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
